// File: rtl/res_fifo_arbiter.sv
// rtl/res_fifo_arbiter.sv - round-robin write arbiter and occupancy tracker for res_fifo
// Grants one producer per cycle into res_fifo and keeps count of reserved entries.
module res_fifo_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 16
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*DATA_W-1:0]         req_data,
  output logic [NUM_REQ-1:0]                gnt,
  input  logic                              fifo_empty,
  input  logic                              fifo_renable,
  output logic                              fifo_wenable,
  output logic [DATA_W-1:0]                 fifo_result_in,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_valid;
  logic              rd_valid;
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Search starts at rr_ptr and wraps; gated by reset so no grant is visible while held in reset.
  always_comb begin : arb
    int j;
    j         = 0;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    if (n_rst && (count < DEPTH_C)) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = int'(rr_ptr) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        if (!gnt_valid && req[PTR_W'(j)]) begin
          gnt_valid = 1'b1;
          gnt_idx   = PTR_W'(j);
        end
      end
    end
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

  // A read against an empty FIFO or a zero count must not pull count below zero.
  assign rd_valid = fifo_renable && !fifo_empty && (count != '0);
  assign full     = (count == DEPTH_C);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rr_ptr         <= '0;
      fifo_wenable   <= 1'b0;
      fifo_result_in <= '0;
      count          <= '0;
    end else begin
      fifo_wenable <= gnt_valid;
      if (gnt_valid) begin
        fifo_result_in <= data_arr[gnt_idx];
        rr_ptr         <= (gnt_idx == LAST_C) ? '0 : gnt_idx + 1'b1;
      end
      case ({gnt_valid, rd_valid})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_res_fifo_arbiter.sv
// tb/tb_res_fifo_arbiter.sv - directed self-checking bench for res_fifo_arbiter
module tb_res_fifo_arbiter;

  logic        tb_clk;
  logic        n_rst;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_empty;
  logic        fifo_renable;
  logic        fifo_wenable;
  logic [15:0] fifo_result_in;
  logic        full;
  logic [3:0]  count;

  int checks;
  int errors;

  res_fifo_arbiter #(.NUM_REQ(4), .FIFO_DEPTH(8), .DATA_W(16)) dut (
    .clk            (tb_clk),
    .n_rst          (n_rst),
    .req            (req),
    .req_data       (req_data),
    .gnt            (gnt),
    .fifo_empty     (fifo_empty),
    .fifo_renable   (fifo_renable),
    .fifo_wenable   (fifo_wenable),
    .fifo_result_in (fifo_result_in),
    .full           (full),
    .count          (count)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic do_reset();
    @(negedge tb_clk);
    n_rst = 1'b0; req = '0; req_data = '0; fifo_renable = 1'b0; fifo_empty = 1'b1;
    @(negedge tb_clk);
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge tb_clk);
    req = 4'hf;
    req_data = {16'd984, 16'd572, 16'd2021, 16'd68};
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp %b", gnt, 4'b0000); end
    checks++; if (fifo_wenable !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", fifo_wenable); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (fifo_result_in !== 16'd0) begin errors++; $display("FAIL reset_data got %0d exp 0", fifo_result_in); end
    n_rst = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt got %b exp %b", gnt, 4'b0001); end
    @(negedge tb_clk);
    req = '0;
    #1;
    checks++; if (fifo_wenable !== 1'b1) begin errors++; $display("FAIL reset_first_wen got %b exp 1", fifo_wenable); end
    checks++; if (fifo_result_in !== 16'd68) begin errors++; $display("FAIL reset_first_data got %0d exp 68", fifo_result_in); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL reset_first_count got %0d exp 1", count); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    req_data[47:32] = 16'd68;
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp %b", gnt, 4'b0100); end
    @(negedge tb_clk);
    req = '0;
    #1;
    checks++; if (fifo_wenable !== 1'b1) begin errors++; $display("FAIL single_wen got %b exp 1", fifo_wenable); end
    checks++; if (fifo_result_in !== 16'd68) begin errors++; $display("FAIL single_data got %0d exp 68", fifo_result_in); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_drop got %b exp 0000", gnt); end
    @(negedge tb_clk);
    #1;
    checks++; if (fifo_wenable !== 1'b0) begin errors++; $display("FAIL single_wen_off got %b exp 0", fifo_wenable); end
    checks++; if (fifo_result_in !== 16'd68) begin errors++; $display("FAIL single_data_hold got %0d exp 68", fifo_result_in); end
  endtask

  task automatic test_rotation();
    logic [15:0] rot_exp [4];
    logic [3:0]  exp_gnt;
    rot_exp[0] = 16'd68; rot_exp[1] = 16'd2021; rot_exp[2] = 16'd572; rot_exp[3] = 16'd984;
    do_reset();
    req_data = {16'd984, 16'd572, 16'd2021, 16'd68};
    req = 4'hf;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) req = '0;
      #1;
      exp_gnt = (i < 4) ? (4'b0001 << i) : 4'b0000;
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rot_gnt%0d got %b exp %b", i, gnt, exp_gnt); end
      if (i > 0) begin
        checks++; if (fifo_wenable !== 1'b1) begin errors++; $display("FAIL rot_wen%0d got %b exp 1", i, fifo_wenable); end
        checks++; if (fifo_result_in !== rot_exp[i-1]) begin errors++; $display("FAIL rot_data%0d got %0d exp %0d", i, fifo_result_in, rot_exp[i-1]); end
      end
      @(negedge tb_clk);
    end
    #1;
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL rot_count got %0d exp 4", count); end
    checks++; if (fifo_wenable !== 1'b0) begin errors++; $display("FAIL rot_wen_off got %b exp 0", fifo_wenable); end
  endtask

  task automatic test_skip();
    do_reset();
    req = 4'b1001;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL skip_gnt0 got %b exp 0001", gnt); end
    @(negedge tb_clk); #1;
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL skip_gnt1 got %b exp 1000", gnt); end
    @(negedge tb_clk); #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL skip_gnt2 got %b exp 0001", gnt); end
    req = '0;
  endtask

  task automatic test_full();
    do_reset();
    req_data = {16'h000d, 16'h000c, 16'h000b, 16'h000a};
    req = 4'hf;
    repeat (8) @(negedge tb_clk);
    #1;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", full); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL full_gnt got %b exp 0000", gnt); end
    @(negedge tb_clk);
    fifo_empty = 1'b0; fifo_renable = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL full_read_gnt got %b exp 0000", gnt); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_hold_count got %0d exp 8", count); end
    @(negedge tb_clk);
    fifo_renable = 1'b0; fifo_empty = 1'b1;
    #1;
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_after_read got %0d exp 7", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_clear got %b exp 0", full); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL full_resume_gnt got %b exp 0001", gnt); end
    @(negedge tb_clk);
    req = '0;
    #1;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_refill got %0d exp 8", count); end
    checks++; if (fifo_result_in !== 16'h000a) begin errors++; $display("FAIL full_refill_data got %h exp 000a", fifo_result_in); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_data[15:0] = 16'h0055;
    req = 4'b0001;
    repeat (5) @(negedge tb_clk);
    #1;
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL simul_pre_count got %0d exp 5", count); end
    fifo_empty = 1'b0; fifo_renable = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL simul_gnt got %b exp 0001", gnt); end
    @(negedge tb_clk);
    req = '0; fifo_renable = 1'b0; fifo_empty = 1'b1;
    #1;
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL simul_count got %0d exp 5", count); end
    checks++; if (fifo_wenable !== 1'b1) begin errors++; $display("FAIL simul_wen got %b exp 1", fifo_wenable); end
    do_reset();
    fifo_renable = 1'b1; fifo_empty = 1'b1;
    repeat (2) @(negedge tb_clk);
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL empty_read_count got %0d exp 0", count); end
    fifo_empty = 1'b0;
    @(negedge tb_clk);
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL underflow_count got %0d exp 0", count); end
    fifo_renable = 1'b0; fifo_empty = 1'b1;
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0010;
    req_data[31:16] = 16'd2021;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_gnt got %b exp 0010", gnt); end
    @(negedge tb_clk);
    req = '0;
    #1;
    checks++; if (fifo_wenable !== 1'b1) begin errors++; $display("FAIL mid_wen_pre got %b exp 1", fifo_wenable); end
    n_rst = 1'b0;
    #1;
    checks++; if (fifo_wenable !== 1'b0) begin errors++; $display("FAIL mid_wen got %b exp 0", fifo_wenable); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", count); end
    checks++; if (fifo_result_in !== 16'd0) begin errors++; $display("FAIL mid_data got %0d exp 0", fifo_result_in); end
    @(negedge tb_clk);
    n_rst = 1'b1; req = 4'hf;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_ptr_gnt got %b exp 0001", gnt); end
    @(negedge tb_clk);
    req = '0;
  endtask

  initial begin
    checks = 0; errors = 0;
    n_rst = 1'b0; req = '0; req_data = '0; fifo_empty = 1'b1; fifo_renable = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_skip();
    test_full();
    test_simultaneous();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
